// File: rtl/pong_ball_if.sv
// Raster-side video bundle between the hvsync generator and the pong ball renderer.
// The hvsync side drives the raster counters and receives the colour bits.
interface pong_ball_if;
    logic [9:0] CounterX;
    logic [8:0] CounterY;
    logic       DisplayArea;
    logic       vgaRed;
    logic       vgaGreen;
    logic       vgaBlue;

    modport master (
        output CounterX,
        output CounterY,
        output DisplayArea,
        input  vgaRed,
        input  vgaGreen,
        input  vgaBlue
    );

    modport slave (
        input  CounterX,
        input  CounterY,
        input  DisplayArea,
        output vgaRed,
        output vgaGreen,
        output vgaBlue
    );
endinterface

// File: rtl/pong_ball.sv
// Pong ball engine: once-per-frame ball motion with wall/paddle bounces and miss counting,
// plus the registered 1-bit RGB pixel renderer for border, paddle and ball.
module pong_ball #(
    parameter int BALL_SIZE    = 16,
    parameter int SPEED        = 2,
    parameter int PADDLE_Y     = 464,
    parameter int PADDLE_W     = 80,
    parameter int BORDER       = 8,
    parameter int SERVE_FRAMES = 60
) (
    input  logic             clk,
    input  logic             reset,
    pong_ball_if.slave       vga,
    input  logic [8:0]       PaddlePosition,
    output logic [9:0]       ball_x,
    output logic [8:0]       ball_y,
    output logic [3:0]       miss_count,
    output logic             playing
);
    localparam int          CW         = $clog2(SERVE_FRAMES + 1);
    localparam logic [10:0] SIZE       = 11'(BALL_SIZE);
    localparam logic [10:0] SPD        = 11'(SPEED);
    localparam logic [10:0] BRD        = 11'(BORDER);
    localparam logic [10:0] RIGHT_WALL = 11'(640 - BORDER);
    localparam logic [10:0] PAD_Y      = 11'(PADDLE_Y);
    localparam logic [10:0] PAD_W      = 11'(PADDLE_W);
    localparam logic [10:0] PAD_H      = 11'd8;
    localparam logic [10:0] FIELD_H    = 11'd480;
    localparam logic [9:0]  CENTRE_X   = 10'(320 - BALL_SIZE / 2);
    localparam logic [8:0]  CENTRE_Y   = 9'(240 - BALL_SIZE / 2);
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);

    typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, MISS = 2'd2} state_t;

    state_t        state_r;
    logic [CW-1:0] serve_cnt_r;
    logic [9:0]    ball_x_r;
    logic [8:0]    ball_y_r;
    logic          dx_r;
    logic          dy_r;
    logic [3:0]    miss_count_r;
    logic          playing_r;
    logic          red_r;
    logic          green_r;
    logic          blue_r;

    logic          tick_s;
    logic [10:0]   x_ext_s;
    logic [10:0]   y_ext_s;
    logic [10:0]   pad_ext_s;
    logic [10:0]   x_next_s;
    logic [10:0]   y_next_s;
    logic          dx_next_s;
    logic          dy_next_s;
    logic          miss_s;
    logic [10:0]   cx_s;
    logic [10:0]   cy_s;
    logic          border_s;
    logic          paddle_s;
    logic          ball_s;

    // The tick lands at the start of vertical blanking so rendering never sees a half-moved ball.
    assign tick_s    = (vga.CounterX == 10'd0) && (vga.CounterY == 9'd480);
    assign x_ext_s   = {1'b0, ball_x_r};
    assign y_ext_s   = {2'b0, ball_y_r};
    assign pad_ext_s = {2'b0, PaddlePosition};

    // Next ball position and direction for a PLAY tick; X and Y are resolved independently.
    always_comb begin
        x_next_s  = x_ext_s;
        y_next_s  = y_ext_s;
        dx_next_s = dx_r;
        dy_next_s = dy_r;
        miss_s    = 1'b0;
        if (dx_r) begin
            if (x_ext_s + SPD + SIZE > RIGHT_WALL) begin
                x_next_s  = RIGHT_WALL - SIZE;
                dx_next_s = 1'b0;
            end else begin
                x_next_s  = x_ext_s + SPD;
                dx_next_s = 1'b1;
            end
        end else begin
            if (x_ext_s < BRD + SPD) begin
                x_next_s  = BRD;
                dx_next_s = 1'b1;
            end else begin
                x_next_s  = x_ext_s - SPD;
                dx_next_s = 1'b0;
            end
        end
        if (!dy_r) begin
            if (y_ext_s < BRD + SPD) begin
                y_next_s  = BRD;
                dy_next_s = 1'b1;
            end else begin
                y_next_s  = y_ext_s - SPD;
                dy_next_s = 1'b0;
            end
        end else begin
            if ((y_ext_s + SIZE <= PAD_Y) && (y_ext_s + SPD + SIZE > PAD_Y) &&
                (x_ext_s + SIZE > pad_ext_s) && (x_ext_s < pad_ext_s + PAD_W)) begin
                y_next_s  = PAD_Y - SIZE;
                dy_next_s = 1'b0;
            end else if (y_ext_s + SPD >= FIELD_H) begin
                miss_s    = 1'b1;
            end else begin
                y_next_s  = y_ext_s + SPD;
                dy_next_s = 1'b1;
            end
        end
    end

    // Game FSM: serve delay, per-frame motion, one-clock miss handling.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= SERVE;
            serve_cnt_r  <= '0;
            ball_x_r     <= CENTRE_X;
            ball_y_r     <= CENTRE_Y;
            dx_r         <= 1'b1;
            dy_r         <= 1'b0;
            miss_count_r <= 4'd0;
            playing_r    <= 1'b0;
        end else begin
            case (state_r)
                SERVE: begin
                    if (tick_s) begin
                        if (serve_cnt_r == SERVE_LAST) begin
                            serve_cnt_r <= '0;
                            state_r     <= PLAY;
                            playing_r   <= 1'b1;
                        end else begin
                            serve_cnt_r <= serve_cnt_r + CW'(1);
                        end
                    end
                end
                PLAY: begin
                    if (tick_s) begin
                        ball_x_r <= x_next_s[9:0];
                        dx_r     <= dx_next_s;
                        if (miss_s) begin
                            state_r   <= MISS;
                            playing_r <= 1'b0;
                        end else begin
                            ball_y_r <= y_next_s[8:0];
                            dy_r     <= dy_next_s;
                        end
                    end
                end
                MISS: begin
                    if (miss_count_r != 4'd15) begin
                        miss_count_r <= miss_count_r + 4'd1;
                    end
                    ball_x_r  <= CENTRE_X;
                    ball_y_r  <= CENTRE_Y;
                    dy_r      <= 1'b0;
                    dx_r      <= ~dx_r;
                    state_r   <= SERVE;
                    playing_r <= 1'b0;
                end
                default: begin
                    state_r   <= SERVE;
                    playing_r <= 1'b0;
                end
            endcase
        end
    end

    assign cx_s = {1'b0, vga.CounterX};
    assign cy_s = {2'b0, vga.CounterY};

    // Object coverage of the current raster pixel.
    always_comb begin
        border_s = (cx_s < BRD) || (cx_s >= RIGHT_WALL) || (cy_s < BRD);
        paddle_s = (cy_s >= PAD_Y) && (cy_s < PAD_Y + PAD_H) &&
                   (cx_s >= pad_ext_s) && (cx_s < pad_ext_s + PAD_W);
        ball_s   = (cx_s >= x_ext_s) && (cx_s < x_ext_s + SIZE) &&
                   (cy_s >= y_ext_s) && (cy_s < y_ext_s + SIZE);
    end

    // Registered colour outputs, blanked outside the visible area.
    always_ff @(posedge clk) begin
        if (reset) begin
            red_r   <= 1'b0;
            green_r <= 1'b0;
            blue_r  <= 1'b0;
        end else begin
            red_r   <= vga.DisplayArea & (border_s | ball_s);
            green_r <= vga.DisplayArea & (paddle_s | ball_s);
            blue_r  <= vga.DisplayArea & ball_s;
        end
    end

    assign vga.vgaRed   = red_r;
    assign vga.vgaGreen = green_r;
    assign vga.vgaBlue  = blue_r;
    assign ball_x       = ball_x_r;
    assign ball_y       = ball_y_r;
    assign miss_count   = miss_count_r;
    assign playing      = playing_r;
endmodule

// File: tb/tb_pong_ball.sv
// Directed bench for pong_ball: serve timing, wall and paddle bounces, misses with
// saturation, pixel rendering boundaries and mid-play reset.
module tb_pong_ball;
    logic       clk;
    logic       reset;
    logic [8:0] PaddlePosition;
    logic [9:0] ball_x;
    logic [8:0] ball_y;
    logic [3:0] miss_count;
    logic       playing;
    int         checks;
    int         failures;

    pong_ball_if vif();

    pong_ball dut (
        .clk            (clk),
        .reset          (reset),
        .vga            (vif),
        .PaddlePosition (PaddlePosition),
        .ball_x         (ball_x),
        .ball_y         (ball_y),
        .miss_count     (miss_count),
        .playing        (playing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic set_idle();
        vif.CounterX    = 10'd100;
        vif.CounterY    = 9'd100;
        vif.DisplayArea = 1'b0;
    endtask

    // One frame tick followed by one idle clock (which also completes a MISS).
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            vif.CounterX    = 10'd0;
            vif.CounterY    = 9'd480;
            vif.DisplayArea = 1'b0;
            @(posedge clk); #1;
            set_idle();
            @(posedge clk); #1;
        end
    endtask

    task automatic check_ball(input string tag, input int ex, input int ey);
        check_val({tag, "_x"}, int'(ball_x), ex);
        check_val({tag, "_y"}, int'(ball_y), ey);
    endtask

    task automatic pix(input string tag, input int x, input int y, input logic da, input int exp_rgb);
        vif.CounterX    = 10'(x);
        vif.CounterY    = 9'(y);
        vif.DisplayArea = da;
        @(posedge clk); #1;
        check_val(tag, int'({vif.vgaRed, vif.vgaGreen, vif.vgaBlue}), exp_rgb);
        set_idle();
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        PaddlePosition = 9'd200;
        set_idle();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check_ball("rst_ball", 312, 232);
        check_val("rst_playing", int'(playing), 0);
        check_val("rst_miss", int'(miss_count), 0);
        check_val("rst_rgb", int'({vif.vgaRed, vif.vgaGreen, vif.vgaBlue}), 0);

        // Pixel rendering with ball at centre and paddle at x=200.
        pix("pix_border_left", 5, 100, 1'b1, 4);
        pix("pix_ball_tl", 312, 232, 1'b1, 7);
        pix("pix_ball_br", 327, 247, 1'b1, 7);
        pix("pix_ball_right_out", 328, 232, 1'b1, 0);
        pix("pix_ball_below_out", 312, 248, 1'b1, 0);
        pix("pix_paddle_tl", 200, 464, 1'b1, 2);
        pix("pix_paddle_br", 279, 471, 1'b1, 2);
        pix("pix_paddle_right_out", 280, 464, 1'b1, 0);
        pix("pix_paddle_below_out", 200, 472, 1'b1, 0);
        pix("pix_border_right", 632, 100, 1'b1, 4);
        pix("pix_inside_right", 631, 100, 1'b1, 0);
        pix("pix_border_top", 100, 7, 1'b1, 4);
        pix("pix_ball_blank", 312, 232, 1'b0, 0);
        pix("pix_border_blank", 5, 100, 1'b0, 0);

        // Serve delay.
        run_ticks(59);
        check_val("serve59_playing", int'(playing), 0);
        check_ball("serve59", 312, 232);
        run_ticks(1);
        check_val("serve60_playing", int'(playing), 1);
        check_ball("serve60", 312, 232);
        run_ticks(1);
        check_ball("play1", 314, 230);

        // Top wall bounce.
        run_ticks(110);
        check_ball("play111", 534, 10);
        run_ticks(1);
        check_ball("play112", 536, 8);
        run_ticks(1);
        check_ball("play113", 538, 8);
        run_ticks(1);
        check_ball("play114", 540, 10);

        // Right wall bounce.
        run_ticks(38);
        check_ball("play152", 616, 86);
        run_ticks(1);
        check_ball("play153", 616, 88);
        run_ticks(1);
        check_ball("play154", 614, 90);

        // Paddle hit at x=200.
        run_ticks(178);
        check_ball("play332", 258, 446);
        run_ticks(1);
        check_ball("play333", 256, 448);
        run_ticks(1);
        check_ball("play334_hit", 254, 448);
        run_ticks(1);
        check_ball("play335", 252, 446);
        check_val("hit_no_miss", int'(miss_count), 0);
        check_val("hit_playing", int'(playing), 1);

        // Miss with paddle far left.
        pulse_reset();
        PaddlePosition = 9'd0;
        run_ticks(60 + 348);
        check_ball("pre_miss", 226, 478);
        check_val("pre_miss_playing", int'(playing), 1);
        run_ticks(1);
        check_val("miss1_count", int'(miss_count), 1);
        check_ball("miss1_centre", 312, 232);
        check_val("miss1_playing", int'(playing), 0);
        run_ticks(61);
        check_ball("miss1_dx_inverted", 314, 230);
        run_ticks(348);
        check_val("miss2_count", int'(miss_count), 2);
        run_ticks(409);
        check_val("miss3_count", int'(miss_count), 3);

        // Reset mid-PLAY while a lit pixel is presented.
        run_ticks(61);
        check_val("pre_reset_playing", int'(playing), 1);
        reset           = 1'b1;
        vif.CounterX    = 10'd5;
        vif.CounterY    = 9'd100;
        vif.DisplayArea = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        set_idle();
        check_val("midrst_miss", int'(miss_count), 0);
        check_ball("midrst_ball", 312, 232);
        check_val("midrst_playing", int'(playing), 0);
        check_val("midrst_rgb", int'({vif.vgaRed, vif.vgaGreen, vif.vgaBlue}), 0);

        // Miss counter saturation.
        for (int k = 1; k <= 16; k++) begin
            run_ticks(409);
            check_val($sformatf("sat_miss%0d", k), int'(miss_count), (k > 15) ? 15 : k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
